// File: rtl/vga_fb_scan_if.sv
// Frame-buffer read port between the VGA scanner (master) and the RGB BRAMs (slave).
interface vga_fb_scan_if;
    localparam int unsigned ADDR_W = 14;

    logic              fb_en;
    logic [ADDR_W-1:0] fb_address;
    logic              red_in;
    logic              green_in;
    logic              blue_in;

    modport master (
        output fb_en,
        output fb_address,
        input  red_in,
        input  green_in,
        input  blue_in
    );

    modport slave (
        input  fb_en,
        input  fb_address,
        output red_in,
        output green_in,
        output blue_in
    );
endinterface

// File: rtl/vga_fb_scan.sv
// 640x480@60 VGA scan-out of a 128x96 1-bit RGB frame buffer with 5x5 pixel replication.
// Define VGA_FB_BORDER_EN to force a white one-pixel ring around the visible area.
module vga_fb_scan #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned SCALE     = 5,
    parameter int unsigned FB_WIDTH  = 128
) (
    input  logic          clk,
    input  logic          reset,
    vga_fb_scan_if.master fb,
    output logic          vga_red,
    output logic          vga_green,
    output logic          vga_blue,
    output logic          vga_hsync,
    output logic          vga_vsync,
    output logic          frame_start
);
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int unsigned CW      = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
    localparam int unsigned AW      = 14;

    logic [DW-1:0] div;
    logic          tick;
    logic [HW-1:0] hcnt, hcnt_n;
    logic [VW-1:0] vcnt, vcnt_n;
    logic [SW-1:0] hsub, hsub_n;
    logic [SW-1:0] vsub, vsub_n;
    logic [CW-1:0] col, col_n;
    logic [AW-1:0] row_base, row_base_n;
    logic          h_wrap, v_wrap;
    logic          vis, vis_n;
    logic          hs_raw, vs_raw;
    logic [2:0]    pix_rgb;

    assign tick   = (div == DW'(CLK_DIV - 1));
    assign h_wrap = (hcnt == HW'(H_TOTAL - 1));
    assign v_wrap = (vcnt == VW'(V_TOTAL - 1));
    assign vis    = (hcnt < HW'(H_VISIBLE)) && (vcnt < VW'(V_VISIBLE));
    assign hs_raw = !((hcnt >= HW'(H_VISIBLE + H_FP)) && (hcnt < HW'(H_VISIBLE + H_FP + H_SYNC)));
    assign vs_raw = !((vcnt >= VW'(V_VISIBLE + V_FP)) && (vcnt < VW'(V_VISIBLE + V_FP + V_SYNC)));

    // Position of the pixel following the current one, in raster and frame-buffer terms.
    always_comb begin
        hcnt_n     = h_wrap ? '0 : hcnt + HW'(1);
        vcnt_n     = vcnt;
        hsub_n     = hsub;
        col_n      = col;
        vsub_n     = vsub;
        row_base_n = row_base;
        if (h_wrap) begin
            vcnt_n = v_wrap ? '0 : vcnt + VW'(1);
            hsub_n = '0;
            col_n  = '0;
            if (v_wrap) begin
                vsub_n     = '0;
                row_base_n = '0;
            end else if (vcnt < VW'(V_VISIBLE - 1)) begin
                // The last visible line never steps row_base, so it stays inside the buffer.
                if (vsub == SW'(SCALE - 1)) begin
                    vsub_n     = '0;
                    row_base_n = row_base + AW'(FB_WIDTH);
                end else begin
                    vsub_n = vsub + SW'(1);
                end
            end
        end else if (vis) begin
            if (hsub == SW'(SCALE - 1)) begin
                hsub_n = '0;
                col_n  = col + CW'(1);
            end else begin
                hsub_n = hsub + SW'(1);
            end
        end
        vis_n = (hcnt_n < HW'(H_VISIBLE)) && (vcnt_n < VW'(V_VISIBLE));
    end

    // Colour for the pixel whose buffer data is arriving now.
    always_comb begin
        pix_rgb = {fb.red_in, fb.green_in, fb.blue_in} & {3{vis}};
`ifdef VGA_FB_BORDER_EN
        if (vis && ((hcnt == '0) || (hcnt == HW'(H_VISIBLE - 1)) ||
                    (vcnt == '0) || (vcnt == VW'(V_VISIBLE - 1)))) begin
            pix_rgb = 3'b111;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div           <= '0;
            hcnt          <= '0;
            vcnt          <= '0;
            hsub          <= '0;
            col           <= '0;
            vsub          <= '0;
            row_base      <= '0;
            fb.fb_en      <= 1'b0;
            fb.fb_address <= '0;
            vga_red       <= 1'b0;
            vga_green     <= 1'b0;
            vga_blue      <= 1'b0;
            vga_hsync     <= 1'b1;
            vga_vsync     <= 1'b1;
            frame_start   <= 1'b0;
        end else begin
            div         <= tick ? '0 : div + DW'(1);
            // Marks the tick that presents pixel (0,0), aligned with the colour/sync outputs.
            frame_start <= tick && (hcnt == '0) && (vcnt == '0);
            if (tick) begin
                hcnt      <= hcnt_n;
                vcnt      <= vcnt_n;
                hsub      <= hsub_n;
                col       <= col_n;
                vsub      <= vsub_n;
                row_base  <= row_base_n;
                fb.fb_en  <= 1'b1;
                if (vis_n) begin
                    fb.fb_address <= row_base_n + AW'(col_n);
                end
                vga_hsync <= hs_raw;
                vga_vsync <= vs_raw;
                vga_red   <= pix_rgb[2];
                vga_green <= pix_rgb[1];
                vga_blue  <= pix_rgb[0];
            end
        end
    end
endmodule

// File: tb/tb_vga_fb_scan.sv
// Scoreboard bench for vga_fb_scan on a reduced raster; honours VGA_FB_BORDER_EN.
module tb_vga_fb_scan;
    localparam int D   = 2;
    localparam int HV  = 40;
    localparam int HF  = 4;
    localparam int HS  = 6;
    localparam int HB  = 4;
    localparam int VV  = 20;
    localparam int VF  = 2;
    localparam int VS  = 2;
    localparam int VB  = 3;
    localparam int SC  = 5;
    localparam int FBW = 8;
    localparam int HT  = HV + HF + HS + HB;
    localparam int VT  = VV + VF + VS + VB;
    localparam int FRAME_T    = HT * VT;
    localparam int FRAME_CLKS = FRAME_T * D;
    localparam int SEL_HS = 0;
    localparam int SEL_VS = 1;
    localparam int SEL_FS = 2;

    logic clk = 1'b0;
    logic reset;
    logic vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, frame_start;

    vga_fb_scan_if fbif ();

    vga_fb_scan #(
        .CLK_DIV(D), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SCALE(SC), .FB_WIDTH(FBW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fb(fbif),
        .vga_red(vga_red),
        .vga_green(vga_green),
        .vga_blue(vga_blue),
        .vga_hsync(vga_hsync),
        .vga_vsync(vga_vsync),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int mode     = 0;
    int ph = 0, pv = 0, disp_h = 0, disp_v = 0;
    logic [13:0] exp_a;
    logic [6:0]  exp_q[$];

    function automatic logic [2:0] pat(input logic [13:0] a);
        case (mode)
            0:       return {a[0] ^ a[3], a[1] ^ a[4], a[2] ^ a[0]};
            1:       return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [13:0] exp_addr(input int h, input int v);
        return 14'((v / SC) * FBW + (h / SC));
    endfunction

    function automatic logic [6:0] exp_pixel(input int h, input int v, input logic [2:0] d);
        logic [2:0] rgb;
        logic hs, vs;
        rgb = 3'b000;
        if (h < HV && v < VV) begin
            rgb = d;
`ifdef VGA_FB_BORDER_EN
            if (h == 0 || h == HV - 1 || v == 0 || v == VV - 1) rgb = 3'b111;
`endif
        end
        hs = !(h >= HV + HF && h < HV + HF + HS);
        vs = !(v >= VV + VF && v < VV + VF + VS);
        return {1'b1, (h == 0 && v == 0), hs, vs, rgb};
    endfunction

    // Registered-read BRAM model; holds its output while disabled.
    always @(posedge clk) begin
        if (reset) begin
            fbif.red_in   <= 1'b0;
            fbif.green_in <= 1'b0;
            fbif.blue_in  <= 1'b0;
        end else if (fbif.fb_en) begin
            {fbif.red_in, fbif.green_in, fbif.blue_in} <= pat(fbif.fb_address);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic sel(input int w);
        case (w)
            SEL_HS:  return vga_hsync;
            SEL_VS:  return vga_vsync;
            default: return frame_start;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int w, input logic val, input int budget,
                            output int n);
        n = 0;
        while (sel(w) !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_timeout"}, 32'(n >= budget), 0);
    endtask

    task automatic apply_reset(input int m);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("reset_outputs",
                 {fbif.fb_en, frame_start, vga_hsync, vga_vsync, vga_red, vga_green, vga_blue},
                 7'b0011000);
        check_eq("reset_fb_address", fbif.fb_address, 0);
        mode = m;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        ph = 0;
        pv = 0;
        exp_a = '0;
        exp_q.delete();
        // Pixel (0,0) shows whatever the disabled BRAM was holding.
        exp_q.push_back(exp_pixel(0, 0, {fbif.red_in, fbif.green_in, fbif.blue_in}));
    endtask

    task automatic run_ticks(input int n);
        logic [6:0] got, e;
        for (int i = 0; i < n; i++) begin
            repeat (D) @(posedge clk);
            #1;
            got = {fbif.fb_en, frame_start, vga_hsync, vga_vsync, vga_red, vga_green, vga_blue};
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 7'bx;
            disp_h = ph;
            disp_v = pv;
            check_eq($sformatf("pixel(%0d,%0d)", disp_h, disp_v), 32'(got), 32'(e));
            ph++;
            if (ph == HT) begin
                ph = 0;
                pv = (pv == VT - 1) ? 0 : pv + 1;
            end
            if (ph < HV && pv < VV) exp_a = exp_addr(ph, pv);
            check_eq($sformatf("fb_address(%0d,%0d)", ph, pv), 32'(fbif.fb_address), 32'(exp_a));
            exp_q.push_back(exp_pixel(ph, pv, pat(exp_addr(ph, pv))));
        end
    endtask

    task automatic measure_timing();
        int n, n1, n2, n3;
        @(negedge clk);
        wait_for("hs_high", SEL_HS, 1'b1, 2 * HT * D, n);
        wait_for("hs_fall", SEL_HS, 1'b0, 2 * HT * D, n);
        wait_for("hs_rise", SEL_HS, 1'b1, 2 * HT * D, n);
        check_eq("hsync_low_clks", n, HS * D);
        wait_for("hs_fall2", SEL_HS, 1'b0, 2 * HT * D, n2);
        check_eq("hsync_period_clks", n + n2, HT * D);

        wait_for("fs_rise", SEL_FS, 1'b1, 2 * FRAME_CLKS, n);
        wait_for("fs_fall", SEL_FS, 1'b0, 2 * HT * D, n1);
        check_eq("frame_start_width", n1, 1);
        wait_for("hs_after_fs", SEL_HS, 1'b0, 2 * HT * D, n2);
        check_eq("hsync_fall_after_frame_start", n1 + n2, (HV + HF) * D);
        wait_for("fs_rise2", SEL_FS, 1'b1, 2 * FRAME_CLKS, n3);
        check_eq("frame_start_period", n1 + n2 + n3, FRAME_CLKS);

        wait_for("vs_fall", SEL_VS, 1'b0, 2 * FRAME_CLKS, n);
        wait_for("vs_rise", SEL_VS, 1'b1, 2 * FRAME_CLKS, n);
        check_eq("vsync_low_clks", n, VS * HT * D);
        wait_for("vs_fall2", SEL_VS, 1'b0, 2 * FRAME_CLKS, n2);
        check_eq("vsync_period_clks", n + n2, FRAME_CLKS);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        // Address pattern data across a full frame and its wrap.
        apply_reset(0);
        run_ticks(FRAME_T + 2 * HT);
        // Advance into hsync-low, then reset mid-line.
        for (int i = 0; i < HT && !(disp_h >= HV + HF && disp_h < HV + HF + HS); i++) begin
            run_ticks(1);
        end
        apply_reset(1);
        run_ticks(FRAME_T + HT);
        measure_timing();
        apply_reset(2);
        run_ticks(FRAME_T + HT);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
